// File: rtl/port_link.sv
// PORTA bridge: processor writes are queued in a small TX FIFO and drained over valid/ready.
// Bytes from an external producer land in a one-entry holding register that the processor reads.
module port_link #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PORT_WR,
    input  logic [DATA_WIDTH-1:0]  PORT_WDATA,
    input  logic                   PORT_RD,
    output logic [DATA_WIDTH-1:0]  PORT_RDATA,
    output logic                   RX_FULL,
    output logic [DATA_WIDTH-1:0]  TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    input  logic [DATA_WIDTH-1:0]  RX_DATA,
    input  logic                   RX_VALID,
    output logic                   RX_READY,
    output logic [$clog2(DEPTH):0] TX_COUNT,
    output logic                   TX_OVF
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  tx_ovf;
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] rx_byte;

    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic rx_accept;

    // DEPTH is a power of two, so the natural binary wrap is the modulo-DEPTH advance.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    assign fifo_full = (count == CNT_W'(DEPTH));
    assign pop       = TX_VALID && TX_READY;
    assign push      = PORT_WR && (!fifo_full || pop);
    assign drop      = PORT_WR && fifo_full && !pop;
    assign rx_accept = RX_VALID && RX_READY;

    // Storage carries no reset; the pointers alone decide what is live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= PORT_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                tx_ovf <= 1'b1;
            end
        end
    end

    // A read only clears the full flag; the byte stays visible on PORT_RDATA.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else if (rx_accept) begin
            rx_full <= 1'b1;
            rx_byte <= RX_DATA;
        end else if (PORT_RD && rx_full) begin
            rx_full <= 1'b0;
        end
    end

    assign TX_COUNT   = count;
    assign TX_VALID   = (count != '0);
    assign TX_DATA    = TX_VALID ? mem[rd_ptr] : '0;
    assign TX_OVF     = tx_ovf;
    assign RX_FULL    = rx_full;
    assign PORT_RDATA = rx_byte;
    assign RX_READY   = !rx_full && !RESET;

endmodule

// File: doc/port_link.md
# port_link

Byte-stream bridge for the far side of the processor's PORTA interface. Processor writes to PORTA (CE_PORTA strobe with ACC_OUT data) are queued in a small FIFO and drained to an external consumer over a valid/ready stream. The bridge also accepts bytes from an external producer into a one-entry holding register. That register drives the processor's PORTA_IN, and a processor read strobe frees it for the next byte.

## Interface
- DATA_WIDTH, 8, byte width of every data path
- DEPTH, 4, TX FIFO entries; power of two, ≥2
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- PORT_WR  in  1  processor write strobe (CE_PORTA); one byte per asserted cycle
- PORT_WDATA  in  DATA_WIDTH  processor write data (ACC_OUT)
- PORT_RD  in  1  processor read strobe; consumes the held RX byte
- PORT_RDATA  out  DATA_WIDTH  held RX byte, wired to PORTA_IN
- RX_FULL  out  1  holding register contains an unread byte
- TX_DATA  out  DATA_WIDTH  head of TX FIFO
- TX_VALID  out  1  TX FIFO non-empty
- TX_READY  in  1  external consumer accepts TX_DATA
- RX_DATA  in  DATA_WIDTH  external producer byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  holding register can accept a byte
- TX_COUNT  out  clog2(DEPTH)+1  current TX FIFO occupancy
- TX_OVF  out  1  sticky flag: a processor write was dropped

## Operation
- Reset (RESET=1 at an edge): TX FIFO flushed, TX_COUNT=0, TX_VALID=0, TX_DATA=0, TX_OVF=0, RX_FULL=0, PORT_RDATA=0. RX_READY=0 while RESET is high. Reset overrides every other event in the same cycle.
- TX push: a push occurs when PORT_WR=1 and (TX_COUNT<DEPTH or a pop occurs in the same cycle). PORT_WDATA is stored at the write pointer, and the write pointer advances modulo DEPTH.
- TX pop: a pop occurs when TX_VALID=1 and TX_READY=1. The read pointer advances modulo DEPTH.
- TX_COUNT: +1 on push only, −1 on pop only, unchanged on push+pop.
- Full drop: PORT_WR=1 while TX_COUNT=DEPTH with no simultaneous pop. The byte is discarded, FIFO contents are unchanged, and TX_OVF is set to 1. TX_OVF stays set until RESET.
- TX_VALID = (TX_COUNT≠0). TX_DATA = entry at the read pointer when TX_VALID=1, else 0 (first-word fall-through).
- TX_DATA and TX_VALID are stable while TX_VALID=1 and TX_READY=0.
- RX_READY = !RX_FULL && !RESET.
- RX accept: RX_VALID=1 and RX_READY=1. PORT_RDATA←RX_DATA and RX_FULL←1.
- RX read: PORT_RD=1 and RX_FULL=1 clears RX_FULL. PORT_RDATA keeps its value and is not zeroed.
- PORT_RD=1 with RX_FULL=0 is ignored. An RX accept can still happen in that cycle.
- Accept and read cannot coincide, because an accept requires RX_FULL=0.
- PORT_WR and PORT_RD are independent; both may be asserted in one cycle.

## Timing
- All outputs are registered state or simple decodes of registered state. RX_READY additionally depends combinationally on RESET.
- No combinational path exists from TX_READY or RX_VALID to any output.
- Push to visibility: PORT_WR at edge k makes TX_VALID=1 and TX_DATA equal to the byte from k+ (after the edge) if the FIFO was empty.
- Minimum write-to-external latency is 1 cycle.
- Pop at edge k: the next entry appears on TX_DATA from k+. Sustained throughput is 1 byte/cycle.
- RX accept at edge k: PORT_RDATA and RX_FULL update from k+, and RX_READY=0 from k+.
- RX read at edge k: RX_READY=1 from k+. The next byte can be accepted at edge k+1, so RX throughput is 1 byte per 2 cycles.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. FIFO order is preserved across wrap.
- Reset mid-transfer: an RX_VALID handshake in the reset cycle is not accepted. A TX handshake in the reset cycle is irrelevant because the FIFO is flushed.

## Test plan
- Reset with RX_VALID=1, RX_DATA=8'hAA, and PORT_WR=1 with PORT_WDATA=8'h55 → after the edge: TX_COUNT=0, TX_VALID=0, TX_DATA=0, RX_FULL=0, PORT_RDATA=0, TX_OVF=0, RX_READY=0 during reset.
- TX_READY=0; write 8'h01,02,03,04 on four consecutive cycles → TX_COUNT=4, TX_DATA=8'h01. Write 8'h05 → dropped, TX_OVF=1, TX_COUNT=4. Then TX_READY=1 → stream 01,02,03,04 on consecutive cycles, then TX_VALID=0.
- FIFO full with TX_READY=1 and PORT_WR=1 with 8'h09 in the same cycle → 8'h09 is accepted, TX_COUNT stays 4, TX_OVF unchanged, and 09 emerges last.
- Wrap: 10 pushes of 8'h10..8'h19 interleaved with pops, never exceeding 3 entries → output order is 10..19 exactly.
- RX_VALID=1 with 8'hFA held → RX_FULL=1, PORT_RDATA=8'hFA, RX_READY=0. Switch RX_DATA to 8'h07 without PORT_RD → PORT_RDATA stays 8'hFA. PORT_RD=1 → RX_FULL=0, and 8'h07 is accepted at the next edge.
- PORT_RD=1 while RX_FULL=0, simultaneously with RX_VALID=1 and 8'h33 → 8'h33 is accepted and RX_FULL=1; the read has no effect.
